// File: rtl/decoder_pkg.sv
// Shared widths and one-hot decode helper for the select decoders.
package decoder_pkg;

    localparam int DEC_IN_W  = 2;
    localparam int DEC_OUT_W = 4;

    function automatic logic [DEC_OUT_W-1:0] onehot_dec(
        input logic [DEC_IN_W-1:0] code
    );
        logic [DEC_OUT_W-1:0] v;
        v = '0;
        for (int k = 0; k < DEC_OUT_W; k++) begin
            v[k] = (code == k[DEC_IN_W-1:0]);
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_onehot_comb.sv
// Purely combinational binary-to-one-hot decode.
// An X/Z select code yields an all-X vector in simulation.
module decoder_onehot_comb
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = DEC_OUT_W
) (
    input  logic [IN_W-1:0]  i,
    output logic [OUT_W-1:0] y
);

    logic [OUT_W-1:0] dec;

    if (OUT_W != (1 << IN_W)) begin : g_bad_width
        $error("decoder_onehot_comb: OUT_W must equal 2**IN_W");
    end

    if (IN_W == DEC_IN_W && OUT_W == DEC_OUT_W) begin : g_pkg
        assign dec = onehot_dec(i);
    end else begin : g_gen
        always_comb begin
            dec = '0;
            for (int k = 0; k < OUT_W; k++) begin
                dec[k] = (i == k[IN_W-1:0]);
            end
        end
    end

    // Synthesis sees the === test as false; simulation propagates unknowns.
    assign y = ((^i) === 1'bx) ? {OUT_W{1'bx}} : dec;

endmodule

// File: rtl/decoder_2to4.sv
// Registered one-hot select decoder with enable and valid flag.
// Define DECODER_2TO4_ACTIVE_LOW_EN to emit y active-low.
module decoder_2to4
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = DEC_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  i,
    output logic [OUT_W-1:0] y,
    output logic             vld
);

    logic [OUT_W-1:0] dec;
    logic [OUT_W-1:0] y_d;
    logic [OUT_W-1:0] y_idle;

    decoder_onehot_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_dec (
        .i (i),
        .y (dec)
    );

`ifdef DECODER_2TO4_ACTIVE_LOW_EN
    assign y_idle = '1;
    assign y_d    = ~dec;
`else
    assign y_idle = '0;
    assign y_d    = dec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            y   <= y_idle;
            vld <= 1'b0;
        end else if (en) begin
            y   <= y_d;
            vld <= 1'b1;
        end else begin
            y   <= y_idle;
            vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_2to4.sv
// Bench for decoder_2to4: directed plan plus random traffic vs a reference model.
// Honours DECODER_2TO4_ACTIVE_LOW_EN when defined.
module tb_decoder_2to4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] i;
    logic [3:0] y;
    logic       vld;

    int checks = 0;
    int errors = 0;

    decoder_2to4 dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .i   (i),
        .y   (y),
        .vld (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the selected line index is the number i, line value 2**i.
    function automatic logic [3:0] model_y(input logic r, input logic e, input int sel);
        int v;
        v = (r || !e) ? 0 : (2 ** sel);
`ifdef DECODER_2TO4_ACTIVE_LOW_EN
        v = 15 - v;
`endif
        return 4'(v);
    endfunction

    task automatic step(input string tag, input logic r, input logic e, input logic [1:0] s);
        logic [3:0] ey;
        logic       ev;
        logic [3:0] act;
        @(negedge clk);
        rst = r;
        en  = e;
        i   = s;
        ey  = model_y(r, e, int'(s));
        ev  = !r && e;
        @(posedge clk);
        #1;
        chk({tag, ":y"}, 32'(y), 32'(ey));
        chk({tag, ":vld"}, 32'(vld), 32'(ev));
`ifdef DECODER_2TO4_ACTIVE_LOW_EN
        act = ~y;
`else
        act = y;
`endif
        chk({tag, ":onehot"}, 32'($countones(act)), vld ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        i   = 2'b11;

        for (int c = 0; c < 3; c++) step("reset", 1'b1, 1'b1, 2'b11);
        step("release", 1'b0, 1'b1, 2'b11);

        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 20; c++) step("sweep", 1'b0, 1'b1, 2'(s));
        end

        step("gate_on", 1'b0, 1'b1, 2'b10);
        step("gate_off", 1'b0, 1'b0, 2'b10);

        step("tog0", 1'b0, 1'b1, 2'b00);
        step("tog1", 1'b0, 1'b1, 2'b11);
        step("tog2", 1'b0, 1'b1, 2'b01);
        step("tog3", 1'b0, 1'b1, 2'b10);

        step("mid_pre", 1'b0, 1'b1, 2'b01);
        step("mid_rst", 1'b1, 1'b1, 2'b01);
        step("mid_post", 1'b0, 1'b1, 2'b01);

        step("dis_rst", 1'b1, 1'b0, 2'b00);

        for (int c = 0; c < 300; c++) begin
            step("rand",
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_2to4.md
Name: decoder_2to4

Overview:
- Registered binary-to-one-hot decoder: a 2-bit select code drives exactly one of 4 output lines high.
- Used as an address/select decoder feeding chip-select or mux-enable logic.
- Output is registered for clean, glitch-free timing.
- Width is parameterised; the default configuration is the 2-to-4 case.

Parameters:
- IN_W, default 2, width of the select code i.
- OUT_W, default 4 (must equal 2**IN_W), width of the one-hot output y. An elaboration-time check rejects any other value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  decode enable. When 0, all outputs are deasserted on the next edge.
- i  input  IN_W  binary select code.
- y  output  OUT_W  registered one-hot decode of i.
- vld  output  1  registered copy of en; marks y as a valid decode.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, y <= all-zeros and vld <= 0. Reset overrides en and i.
- Enabled decode: on a rising edge with rst=0 and en=1:
  - y <= (1 << i), so bit k of y is 1 iff i == k;
  - vld <= 1.
- Mapping for the default configuration: i=00 -> y=0001, i=01 -> y=0010, i=10 -> y=0100, i=11 -> y=1000.
- Disabled: on a rising edge with rst=0 and en=0, y <= all-zeros and vld <= 0.
- Latency: exactly 1 clock from a change of i/en to the corresponding y/vld. There is no combinational path from inputs to outputs.
- Invariant: while vld=1, y has exactly one bit set. While vld=0, y is all-zeros.
- Back-to-back changes: i may change every cycle, and each cycle's value is decoded independently. There is no hold or hysteresis.
- Reset mid-operation: an asserted rst clears the outputs on that edge regardless of en. Decoding resumes on the first edge after rst deasserts.
- Unknown inputs: if i contains X/Z while en=1, y is driven all-X in simulation (not silently zero). Synthesis treats this as don't-care.
- No state machine; the block is a pure registered function.

Optional Feature:
- Macro: DECODER_2TO4_ACTIVE_LOW_EN.
- Defined: y is emitted active-low.
  - Reset and en=0 drive all-ones.
  - A decode drives ~(1 << i), e.g. i=10 -> y=1011.
  - vld is unaffected.
- Undefined: active-high behaviour as specified above.
- The polarity inversion is applied at the register input, so the output remains register-driven.

Decomposition:
- Shared package decoder_pkg holds:
  - localparam DEC_IN_W = 2;
  - localparam DEC_OUT_W = 4;
  - a function onehot_dec(input [IN_W-1:0]) returning the OUT_W-bit one-hot vector, shared with other select decoders.
- Optional sub-module decoder_onehot_comb: the purely combinational decode, instantiated ahead of the output register.
- The top level contains only the register, reset and enable handling, and the polarity macro.

Test Plan:
- Reset: rst=1 for 3 cycles with en=1, i=11 -> y=0000 and vld=0 throughout. First edge after release -> y=1000, vld=1.
- Full sweep: en=1, i=00, 01, 10, 11, each held 200 ns -> y=0001, 0010, 0100, 1000, each one cycle after the i change; vld=1.
- Enable gating: en=1 with i=10 for one cycle, then en=0 -> y=0100, vld=1, then y=0000, vld=0 on the next edge.
- Every-cycle toggling: i = 00, 11, 01, 10 on consecutive edges -> y = 0001, 1000, 0010, 0100 with 1-cycle lag. The one-hot invariant assertion must pass every cycle.
- Mid-stream reset: decoding i=01 (y=0010) when rst pulses for 1 cycle -> y=0000, vld=0 on that edge, then y=0010 on the following edge.
- Macro build (DECODER_2TO4_ACTIVE_LOW_EN defined): reset -> y=1111; i=01 with en=1 -> y=1101; en=0 -> y=1111.
